// File: rtl/store_commit_ctrl.sv
// Post-commit store buffer with a shared D-memory request port for store drain and LSQ loads.
// Define STORE_FWD_EN to enable same-cycle forwarding of exact-match WORD stores to WORD loads.
`timescale 1ns/1ps

// state    | meaning
// IDLE     | no request outstanding; arbitrate store drain vs load (or forward)
// ISSUE_LD | load request held on the memory port until mem_req_ready
// ISSUE_ST | head store held on the memory port until mem_req_ready, then popped
module store_commit_ctrl #(
    parameter int SB_DEPTH     = 4,
    parameter int DRAIN_THRESH = 3,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmt_valid,
    input  logic              cmt_wr_mem,
    input  logic [ADDR_W-1:0] cmt_addr,
    input  logic [DATA_W-1:0] cmt_data,
    input  logic [1:0]        cmt_size,
    output logic              commit_stall,
    output logic              sb_empty,
    output logic              sb_overflow,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    output logic              ld_grant,
    output logic              ld_fwd_valid,
    output logic [DATA_W-1:0] ld_fwd_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_is_store,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(SB_DEPTH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(DRAIN_THRESH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_LD = 2'd1,
        ISSUE_ST = 2'd2
    } state_t;

    state_t state;

    logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
    logic [DATA_W-1:0] sb_data [SB_DEPTH];
    logic [1:0]        sb_size [SB_DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             enq_try;
    logic             enq;
    logic             deq;
    logic             alias_hit;
    logic [PTR_W-1:0] yng_idx;
    logic [PTR_W-1:0] scan_idx;
    logic             fwd_ok;
    logic             fwd_hit;
    logic             blocked;
    logic             start_st;
    logic             start_ld;

    assign enq_try      = cmt_valid && cmt_wr_mem;
    assign enq          = enq_try && (count != DEPTH_C);
    assign deq          = (state == ISSUE_ST) && mem_req_ready;
    assign commit_stall = (count == DEPTH_C);
    assign sb_empty     = (count == '0);

    // Scan oldest to youngest so the last match is the youngest aliasing entry.
    always_comb begin
        alias_hit = 1'b0;
        yng_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            scan_idx = head + PTR_W'(k);
            if ((CNT_W'(k) < count) &&
                (sb_addr[scan_idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
                alias_hit = 1'b1;
                yng_idx   = scan_idx;
            end
        end
    end

`ifdef STORE_FWD_EN
    assign fwd_ok = alias_hit &&
                    (sb_addr[yng_idx] == ld_addr) &&
                    (sb_size[yng_idx] == 2'd2) &&
                    (ld_size == 2'd2);
    // Once the drain threshold is reached the store start wins over forwarding.
    assign fwd_hit      = (state == IDLE) && ld_req && fwd_ok && (count < THRESH_C);
    assign ld_fwd_valid = fwd_hit;
    assign ld_fwd_data  = fwd_hit ? sb_data[yng_idx] : '0;
`else
    logic fwd_unused;
    assign fwd_unused   = ^yng_idx;
    assign fwd_ok       = 1'b0;
    assign fwd_hit      = 1'b0;
    assign ld_fwd_valid = 1'b0;
    assign ld_fwd_data  = '0;
`endif

    assign blocked  = alias_hit && !fwd_ok;
    assign start_st = (state == IDLE) && (count != '0) &&
                      ((count >= THRESH_C) || !ld_req || blocked);
    assign start_ld = (state == IDLE) && ld_req && !blocked && !start_st && !fwd_hit;
    assign ld_grant = ((state == ISSUE_LD) && mem_req_ready) || fwd_hit;

    // Entry storage carries no reset; validity is defined purely by head/count.
    always_ff @(posedge clock) begin
        if (enq) begin
            sb_addr[tail] <= cmt_addr;
            sb_data[tail] <= cmt_data;
            sb_size[tail] <= cmt_size;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            sb_overflow <= 1'b0;
        end else begin
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            if (enq && !deq) begin
                count <= count + 1'b1;
            end else if (!enq && deq) begin
                count <= count - 1'b1;
            end
            if (enq_try && (count == DEPTH_C)) begin
                sb_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            mem_req_valid <= 1'b0;
            mem_is_store  <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_size      <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_st) begin
                        state         <= ISSUE_ST;
                        mem_req_valid <= 1'b1;
                        mem_is_store  <= 1'b1;
                        mem_addr      <= sb_addr[head];
                        mem_wdata     <= sb_data[head];
                        mem_size      <= sb_size[head];
                    end else if (start_ld) begin
                        state         <= ISSUE_LD;
                        mem_req_valid <= 1'b1;
                        mem_is_store  <= 1'b0;
                        mem_addr      <= ld_addr;
                        mem_wdata     <= '0;
                        mem_size      <= ld_size;
                    end
                end
                ISSUE_LD, ISSUE_ST: begin
                    if (mem_req_ready) begin
                        state         <= IDLE;
                        mem_req_valid <= 1'b0;
                        mem_is_store  <= 1'b0;
                        mem_addr      <= '0;
                        mem_wdata     <= '0;
                        mem_size      <= 2'd0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
